// File: rtl/seg7_capture.sv
// Seven-segment bus monitor: debounces (digit, pattern) pairs and recovers hex nibbles per digit.
// Optional saturating error counter enabled by defining SEG7_CAP_ERRCNT_EN.
module seg7_capture #(
    parameter int DIGITS     = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     dp,
    output logic                  upd_valid,
    output logic [2:0]            upd_idx,
    output logic                  err,
    output logic [7:0]            err_cnt
);

    // state | meaning
    // IDLE  | no valid digit select seen
    // TRACK | counting consecutive identical (digit, pattern) samples
    // HOLD  | current pair committed, waiting for a change
    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    state_t      state, state_nxt;
    logic [7:0]  seg_q;
    logic [DIGITS-1:0] an_q;
    logic [7:0]  cnt, cnt_nxt;
    logic [2:0]  cur_idx;
    logic [7:0]  cur_s;
    logic [2:0]  idx_now;
    logic        sel_valid;
    logic        differ;
    logic        latch;
    logic        commit;
    logic        pat_known;
    logic        pat_blank;
    logic [3:0]  pat_nib;

    // {known, blank, nibble} for s[7:1] = {a..g}
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'h7E: decode = 6'b10_0000;
            7'h30: decode = 6'b10_0001;
            7'h6D: decode = 6'b10_0010;
            7'h79: decode = 6'b10_0011;
            7'h33: decode = 6'b10_0100;
            7'h5B: decode = 6'b10_0101;
            7'h5F: decode = 6'b10_0110;
            7'h70: decode = 6'b10_0111;
            7'h7F: decode = 6'b10_1000;
            7'h7B: decode = 6'b10_1001;
            7'h77: decode = 6'b10_1010;
            7'h1F: decode = 6'b10_1011;
            7'h4E: decode = 6'b10_1100;
            7'h3D: decode = 6'b10_1101;
            7'h4F: decode = 6'b10_1110;
            7'h47: decode = 6'b10_1111;
            7'h00: decode = 6'b01_0000;
            default: decode = 6'b00_0000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            an_q  <= '1;
        end else begin
            seg_q <= ~seg_n;
            an_q  <= an_n;
        end
    end

    always_comb begin
        idx_now = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) idx_now = 3'(i);
        end
    end

    assign sel_valid = ($countones(~an_q) == 1);
    assign differ    = (idx_now != cur_idx) || (seg_q != cur_s);
    assign {pat_known, pat_blank, pat_nib} = decode(cur_s[7:1]);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_nxt = TRACK;
                    latch     = 1'b1;
                    cnt_nxt   = 8'd1;
                end
            end
            TRACK: begin
                if (!sel_valid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else if (differ) begin
                    latch   = 1'b1;
                    cnt_nxt = 8'd1;
                end else if (cnt + 8'd1 == 8'(STABLE_CYC)) begin
                    commit    = 1'b1;
                    state_nxt = HOLD;
                    cnt_nxt   = 8'(STABLE_CYC);
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            HOLD: begin
                if (!sel_valid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else if (differ) begin
                    state_nxt = TRACK;
                    latch     = 1'b1;
                    cnt_nxt   = 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_idx   <= '0;
            cur_s     <= '0;
            value     <= '0;
            blank     <= '1;
            dp        <= '0;
            upd_valid <= 1'b0;
            upd_idx   <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            upd_valid <= 1'b0;
            err       <= 1'b0;
            if (latch) begin
                cur_idx <= idx_now;
                cur_s   <= seg_q;
            end
            if (commit) begin
                if (pat_known || pat_blank) begin
                    upd_valid <= 1'b1;
                    upd_idx   <= cur_idx;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cur_idx == 3'(i)) begin
                            dp[i]    <= cur_s[0];
                            blank[i] <= pat_blank;
                            if (pat_known) value[4*i +: 4] <= pat_nib;
                        end
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef SEG7_CAP_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (commit && !pat_known && !pat_blank && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed-vector bench for seg7_capture with hand-computed expectations.
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  seg_n;
    logic [7:0]  an_n;
    logic [31:0] value;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic        upd_valid;
    logic [2:0]  upd_idx;
    logic        err;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int upd_pulses = 0;
    int err_pulses = 0;
    logic [2:0] idx_log[$];
    logic [7:0] pat[0:8];

    seg7_capture #(.DIGITS(8), .STABLE_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
        .value(value), .blank(blank), .dp(dp),
        .upd_valid(upd_valid), .upd_idx(upd_idx),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (upd_valid) begin
                upd_pulses++;
                idx_log.push_back(upd_idx);
            end
            if (err) err_pulses++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base_u, base_e, first;
    logic [7:0] exp_cnt1, exp_cnt_sat;

    initial begin
`ifdef SEG7_CAP_ERRCNT_EN
        exp_cnt1 = 8'd1;
        exp_cnt_sat = 8'd255;
`else
        exp_cnt1 = 8'd0;
        exp_cnt_sat = 8'd0;
`endif
        pat[0] = 8'hFC; pat[1] = 8'h60; pat[2] = 8'hDA; pat[3] = 8'hF2;
        pat[4] = 8'h66; pat[5] = 8'hB6; pat[6] = 8'hBE; pat[7] = 8'hE0;
        pat[8] = 8'hFE;

        // reset with all selects low
        seg_n = 8'h00;
        an_n  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("rst_value", value, 32'h0);
        check("rst_blank", {24'h0, blank}, 32'hFF);
        check("rst_dp", {24'h0, dp}, 32'h0);
        check("rst_upd", {31'h0, upd_valid}, 32'h0);
        check("rst_idx", {29'h0, upd_idx}, 32'h0);
        check("rst_errcnt", {24'h0, err_cnt}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("post_rst_upd_pulses", upd_pulses, 0);
        check("post_rst_err_pulses", err_pulses, 0);
        check("post_rst_blank", {24'h0, blank}, 32'hFF);

        // digit 0 pattern held 6 cycles: latency 1+STABLE_CYC
        base_u = upd_pulses;
        seg_n = ~8'hFC;
        an_n  = 8'hFE;
        first = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (upd_valid && first == 0) first = c;
        end
        check("d0_latency", first, 5);
        check("d0_pulses", upd_pulses - base_u, 1);
        check("d0_idx", {29'h0, upd_idx}, 32'h0);
        check("d0_value", {28'h0, value[3:0]}, 32'h0);
        check("d0_blank", {31'h0, blank[0]}, 32'h0);
        check("d0_dp", {31'h0, dp[0]}, 32'h0);

        // digit 3 toggling 5/6 every 2 cycles never settles
        base_u = upd_pulses;
        an_n = 8'hF7;
        for (int t = 0; t < 6; t++) begin
            seg_n = (t % 2 == 0) ? ~8'hB6 : ~8'hBE;
            tick(2);
        end
        check("toggle_no_commit", upd_pulses - base_u, 0);
        seg_n = ~8'hBE;
        tick(6);
        check("d3_pulses", upd_pulses - base_u, 1);
        check("d3_value", {28'h0, value[15:12]}, 32'h6);
        check("d3_idx", {29'h0, upd_idx}, 32'h3);

        // unknown pattern on digit 4
        base_u = upd_pulses;
        base_e = err_pulses;
        an_n  = 8'hEF;
        seg_n = ~8'h02;
        tick(6);
        check("unk_err_pulses", err_pulses - base_e, 1);
        check("unk_no_upd", upd_pulses - base_u, 0);
        check("unk_value4", {28'h0, value[19:16]}, 32'h0);
        check("unk_blank4", {31'h0, blank[4]}, 32'h1);
        check("unk_errcnt1", {24'h0, err_cnt}, {24'h0, exp_cnt1});
        base_e = err_pulses;
        for (int k = 0; k < 300; k++) begin
            an_n = 8'hFF;
            tick(2);
            an_n = 8'hEF;
            tick(6);
        end
        check("unk_300_pulses", err_pulses - base_e, 300);
        check("errcnt_sat", {24'h0, err_cnt}, {24'h0, exp_cnt_sat});

        // blank pattern with decimal point on digit 5
        base_u = upd_pulses;
        an_n  = 8'hDF;
        seg_n = ~8'h01;
        tick(6);
        check("blank5_pulses", upd_pulses - base_u, 1);
        check("blank5_idx", {29'h0, upd_idx}, 32'h5);
        check("blank5_blank", {31'h0, blank[5]}, 32'h1);
        check("blank5_dp", {31'h0, dp[5]}, 32'h1);
        check("blank5_value", {28'h0, value[23:20]}, 32'h0);

        // two selects low
        base_u = upd_pulses;
        base_e = err_pulses;
        an_n  = 8'hFC;
        seg_n = ~8'h60;
        tick(10);
        check("multi_no_upd", upd_pulses - base_u, 0);
        check("multi_no_err", err_pulses - base_e, 0);
        check("multi_idx_hold", {29'h0, upd_idx}, 32'h5);

        // scan eight digits, 5 cycles each
        idx_log.delete();
        for (int i = 0; i < 8; i++) begin
            an_n  = ~(8'h01 << i);
            seg_n = ~pat[i];
            tick(5);
        end
        check("scan_pulses", idx_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < idx_log.size()) check($sformatf("scan_idx%0d", i), {29'h0, idx_log[i]}, i);
        end
        check("scan_value", value, 32'h76543210);
        check("scan_blank", {24'h0, blank}, 32'h0);
        check("scan_dp", {24'h0, dp}, 32'h0);

        // reset in the middle of a second scan
        for (int i = 0; i < 2; i++) begin
            an_n  = ~(8'h01 << i);
            seg_n = ~pat[8];
            tick(5);
        end
        an_n = 8'hFB;
        tick(2);
        check("mid_value", value, 32'h76543288);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_value", value, 32'h0);
        check("mid_rst_blank", {24'h0, blank}, 32'hFF);
        check("mid_rst_upd", {31'h0, upd_valid}, 32'h0);
        check("mid_rst_errcnt", {24'h0, err_cnt}, 32'h0);
        base_u = upd_pulses;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("post_mid_no_commit", upd_pulses - base_u, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
